// File: rtl/conv_window_gen.sv
// conv_window_gen
// ---------------------------------------------------------------------------
// Stream-to-window stage for the convolution datapath. It pops 3-lane pixel
// words from an upstream FIFO in raster order and keeps the two previous
// image rows in line buffers. Each full 3x3 neighbourhood is emitted as one
// wide window word over a valid/ready handshake. Border positions produce no
// window, so a frame yields (IMG_W-2)*(IMG_H-2) windows.
//
// Parameters:
//   DATA_WIDTH  width of one lane (one pixel word is 3*DATA_WIDTH bits)
//   IMG_W       pixels per row, >= 3
//   IMG_H       rows per frame, >= 3
//
// Ports:
//   clk          clock, all state on the rising edge
//   rst          asynchronous active-high reset
//   fifo_dout    pixel word from the FIFO, valid the cycle after fifo_rd_req
//   fifo_empty   FIFO has no data
//   fifo_rd_req  pop request to the FIFO
//   win_data     window; entry k=r*3+c at [k*3*DATA_WIDTH +: 3*DATA_WIDTH],
//                r=0 is the top row, c=0 the left column
//   win_valid    win_data holds a window
//   win_ready    consumer takes the window on this edge when win_valid=1
//   busy         a frame is in progress, a read is in flight or the skid
//                holds data
//   win_last     (WIN_LAST_EN only) marks the last window of the frame
//
// Build option: define WIN_LAST_EN to add the win_last output.
// ---------------------------------------------------------------------------
module conv_window_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_W      = 224,
    parameter int IMG_H      = 224
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3*DATA_WIDTH-1:0]    fifo_dout,
    input  logic                       fifo_empty,
    output logic                       fifo_rd_req,
    output logic [27*DATA_WIDTH-1:0]   win_data,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic                       busy
`ifdef WIN_LAST_EN
   ,output logic                       win_last
`endif
);

    localparam int PW = 3 * DATA_WIDTH;
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]    state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [1:0]    skid_occ;
    logic          inflight;
    logic [1:0]    pending;
    logic          pop;
    logic          win_done;
    logic          handshake;
    logic          all_clear;
    logic          wr_slot0;

    logic [PW-1:0] skid_p0 [2];
    logic [PW-1:0] lb0 [IMG_W];
    logic [PW-1:0] lb1 [IMG_W];
    logic [PW-1:0] win_p1 [9];
    logic          vld_p1;
`ifdef WIN_LAST_EN
    logic          last_p1;
`endif

    // A pop is an accept: the head skid word enters the window at (x,y).
    assign pop       = (skid_occ != 2'd0) && (!vld_p1 || win_ready);
    assign win_done  = pop && (x >= XW'(2)) && (y >= YW'(2));
    assign handshake = vld_p1 && win_ready;

    // Words already owned by the stage (buffered or in flight) after this
    // cycle's pop; requesting only below two keeps the skid from overrunning.
    assign pending     = skid_occ + {1'b0, inflight} - {1'b0, pop};
    assign fifo_rd_req = !rst && !fifo_empty && (pending < 2'd2);

    // Stale window/line-buffer data never matters once the frame counters,
    // skid and in-flight state are clear, so that is all IDLE requires.
    assign all_clear = (x == '0) && (y == '0) && (skid_occ == 2'd0)
                       && !inflight && !vld_p1;

    // The new skid word lands in slot 0 when the skid is empty after the pop.
    assign wr_slot0 = (skid_occ == 2'd0) || ((skid_occ == 2'd1) && pop);

    // ---- control: read tracking, frame position, output valid ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            x        <= '0;
            y        <= '0;
            skid_occ <= 2'd0;
            inflight <= 1'b0;
            vld_p1   <= 1'b0;
`ifdef WIN_LAST_EN
            last_p1  <= 1'b0;
`endif
        end else begin
            inflight <= fifo_rd_req;

            case ({inflight, pop})
                2'b10:   skid_occ <= skid_occ + 2'd1;
                2'b01:   skid_occ <= skid_occ - 2'd1;
                default: skid_occ <= skid_occ;
            endcase

            if (pop) begin
                if (x == X_LAST) begin
                    x <= '0;
                    if (y == Y_LAST) y <= '0;
                    else             y <= y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end

            if (win_done)       vld_p1 <= 1'b1;
            else if (handshake) vld_p1 <= 1'b0;

`ifdef WIN_LAST_EN
            if (win_done)       last_p1 <= (x == X_LAST) && (y == Y_LAST);
            else if (handshake) last_p1 <= 1'b0;
`endif

            case (state)
                ST_IDLE: if (fifo_rd_req)               state <= ST_RUN;
                default: if (all_clear && !fifo_rd_req) state <= ST_IDLE;
            endcase
        end
    end

    // ---- stage p0: input skid buffer, captured one cycle after a request ----
    always_ff @(posedge clk) begin
        if (pop)
            skid_p0[0] <= skid_p0[1];
        if (inflight) begin
            if (wr_slot0) skid_p0[0] <= fifo_dout;
            else          skid_p0[1] <= fifo_dout;
        end
    end

    // Line buffers: lb0 holds row y-2, lb1 row y-1 at each column.
    always_ff @(posedge clk) begin
        if (pop) begin
            lb0[x] <= lb1[x];
            lb1[x] <= skid_p0[0];
        end
    end

    // ---- stage p1: 3x3 window shift register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) win_p1[k] <= '0;
        end else if (pop) begin
            for (int r = 0; r < 3; r++) begin
                win_p1[r*3]     <= win_p1[r*3 + 1];
                win_p1[r*3 + 1] <= win_p1[r*3 + 2];
            end
            win_p1[2] <= lb0[x];
            win_p1[5] <= lb1[x];
            win_p1[8] <= skid_p0[0];
        end
    end

    for (genvar k = 0; k < 9; k++) begin : g_pack
        assign win_data[k*PW +: PW] = win_p1[k];
    end

    assign win_valid = vld_p1;
    assign busy      = (state == ST_RUN);
`ifdef WIN_LAST_EN
    assign win_last  = last_p1;
`endif

endmodule
